mean_update_engine: RTL

- Reader/consumer side of the cluster accumulation interface: takes the per-cluster channel sums and pixel counters produced by the cluster engine at the end of an image pass.
- Computes each cluster's new mean by sequential division and drives the mean and enable buses back to the cluster engine.
- Flags convergence when no mean moved by more than a threshold.
- Sits between the cluster engine and the iteration controller, one instance per engine.

---
 rtl/mean_update_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mean_update_engine.sv
// Per-cluster mean update: divides the channel sums by the pixel count, writes back the means
// and flags convergence. States: IDLE wait | LOAD latch cluster | DIV 24-step divide | WRITE update mean | DONE pulse.
module mean_update_engine #(
  parameter int T      = 16,
  parameter int THRESH = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [24*T-1:0]   meanInit,
  input  logic              start,
  input  logic [72*T-1:0]   accumolator,
  input  logic [12*T-1:0]   counters,
  output logic [24*T-1:0]   meanOut,
  output logic [T-1:0]      enabled,
  output logic              busy,
  output logic              done,
  output logic              converged
);

  localparam int IW = (T > 1) ? $clog2(T) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(T - 1);
  localparam logic [7:0] THRESH_B = 8'(THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          keep;
  logic          moved;
  logic [4:0]    div_cnt;
  logic [11:0]   divisor;
  logic [23:0]   quo [3];
  logic [11:0]   rem [3];

  logic [12:0]   trial   [3];
  logic [11:0]   rem_nxt [3];
  logic [23:0]   quo_nxt [3];
  logic [7:0]    sat     [3];
  logic [7:0]    old_ch  [3];
  logic [7:0]    new_ch  [3];
  logic [7:0]    abs_d   [3];
  logic [23:0]   old_mean;
  logic [23:0]   new_mean;
  logic          moved_now;

  // Restoring divider step: the remainder stays below the divisor, so 12 bits suffice after subtract.
  always_comb begin
    old_mean  = meanOut[idx*24 +: 24];
    new_mean  = old_mean;
    moved_now = 1'b0;
    for (int c = 0; c < 3; c++) begin
      trial[c] = {rem[c], quo[c][23]};
      if (trial[c] >= {1'b0, divisor}) begin
        rem_nxt[c] = trial[c][11:0] - divisor;
        quo_nxt[c] = {quo[c][22:0], 1'b1};
      end else begin
        rem_nxt[c] = trial[c][11:0];
        quo_nxt[c] = {quo[c][22:0], 1'b0};
      end
      sat[c] = (quo[c][23:8] != 16'd0) ? 8'hFF : quo[c][7:0];
    end
    if (!keep) new_mean = {sat[2], sat[1], sat[0]};
    for (int c = 0; c < 3; c++) begin
      old_ch[c] = old_mean[c*8 +: 8];
      new_ch[c] = new_mean[c*8 +: 8];
      abs_d[c]  = (new_ch[c] >= old_ch[c]) ? (new_ch[c] - old_ch[c]) : (old_ch[c] - new_ch[c]);
      if (abs_d[c] > THRESH_B) moved_now = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      keep      <= 1'b0;
      moved     <= 1'b0;
      div_cnt   <= '0;
      divisor   <= '0;
      meanOut   <= '0;
      enabled   <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        quo[c] <= '0;
        rem[c] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init) begin
            meanOut   <= meanInit;
            enabled   <= '1;
            converged <= 1'b0;
          end else if (start) begin
            idx   <= '0;
            moved <= 1'b0;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          divisor <= counters[idx*12 +: 12];
          div_cnt <= 5'd23;
          for (int c = 0; c < 3; c++) begin
            quo[c] <= accumolator[idx*72 + c*24 +: 24];
            rem[c] <= '0;
          end
          if (counters[idx*12 +: 12] == 12'd0) begin
            keep  <= 1'b1;
            state <= S_WRITE;
          end else begin
            keep  <= 1'b0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          for (int c = 0; c < 3; c++) begin
            quo[c] <= quo_nxt[c];
            rem[c] <= rem_nxt[c];
          end
          if (div_cnt == 5'd0) state <= S_WRITE;
          else div_cnt <= div_cnt - 1'b1;
        end
        S_WRITE: begin
          meanOut[idx*24 +: 24] <= new_mean;
          enabled[idx]          <= ~keep;
          if (moved_now) moved <= 1'b1;
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          converged <= ~moved;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
